// File: rtl/delay_line_var.sv
// Multi-channel valid-tagged delay line with run-time selectable delay (0..MAX_DELAY).
// Reports refill after reconfiguration or flush on busy_out.
module delay_line_var #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned MAX_DELAY  = 16,
  localparam int unsigned DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_in,
  input  logic                         flush_in,
  input  logic                         cfg_load_in,
  input  logic [DLY_W-1:0]             cfg_delay_in,
  input  logic                         src_valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] src_data_in,
  output logic                         dst_valid_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] dst_data_out,
  output logic                         busy_out,
  output logic                         cfg_err_out,
  output logic [DLY_W-1:0]             cur_delay_out
);

  localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;
  localparam int unsigned IDX_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  logic [BUS_W-1:0]     stage_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] tag_q;
  logic [MAX_DELAY-1:0] tag_d;
  logic [DLY_W-1:0]     delay_q;
  logic                 cfg_err_q;
  state_e               state_q;
  state_e               state_d;
  logic [DLY_W-1:0]     cnt_q;
  logic [DLY_W-1:0]     cnt_d;
  logic [DLY_W:0]       cnt_inc;
  logic [DLY_W:0]       cnt_last;
  logic [IDX_W-1:0]     tap_idx;

  // Valid-tag chain: shift on enable, then apply clears (load keeps the same-edge sample).
  always_comb begin
    tag_d = tag_q;
    if (en_in) begin
      tag_d[0] = src_valid_in;
      for (int unsigned i = 1; i < MAX_DELAY; i++) begin
        tag_d[IDX_W'(i)] = tag_q[IDX_W'(i - 1)];
      end
    end
    if (cfg_load_in) begin
      tag_d    = '0;
      tag_d[0] = en_in & src_valid_in;
    end else if (flush_in) begin
      tag_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_DELAY; i++) begin
        stage_q[IDX_W'(i)] <= '0;
      end
      tag_q     <= '0;
      delay_q   <= MAX_D;
      cfg_err_q <= 1'b0;
    end else begin
      if (en_in) begin
        stage_q[0] <= src_data_in;
        for (int unsigned i = 1; i < MAX_DELAY; i++) begin
          stage_q[IDX_W'(i)] <= stage_q[IDX_W'(i - 1)];
        end
      end
      tag_q     <= tag_d;
      cfg_err_q <= cfg_load_in && (cfg_delay_in > MAX_D);
      if (cfg_load_in) begin
        delay_q <= (cfg_delay_in > MAX_D) ? MAX_D : cfg_delay_in;
      end
    end
  end

  // Refill tracker state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Leave FILL on the enabled edge where the count reaches delay_q-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_inc  = {1'b0, cnt_q} + (DLY_W + 1)'(1);
    cnt_last = {1'b0, delay_q} - (DLY_W + 1)'(1);
    if (cfg_load_in || flush_in) begin
      state_d = ST_FILL;
      cnt_d   = '0;
    end else if (state_q == ST_FILL) begin
      if (delay_q == '0) begin
        state_d = ST_RUN;
      end else if (en_in) begin
        cnt_d = cnt_inc[DLY_W-1:0];
        if (cnt_inc >= cnt_last) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  assign tap_idx = IDX_W'(delay_q - DLY_W'(1));

  // Output tap; delay 0 bypasses the line combinationally.
  always_comb begin
    dst_valid_out = 1'b0;
    dst_data_out  = '0;
    if (delay_q == '0) begin
      dst_valid_out = src_valid_in;
      dst_data_out  = src_data_in;
    end else begin
      dst_valid_out = tag_q[tap_idx];
      dst_data_out  = stage_q[tap_idx];
    end
  end

  assign busy_out      = (state_q == ST_FILL);
  assign cfg_err_out   = cfg_err_q;
  assign cur_delay_out = delay_q;

endmodule

// File: tb/tb_delay_line_var.sv
// Self-checking bench for delay_line_var: sample-history model plus directed literal checks.
module tb_delay_line_var;

  localparam int unsigned BW = 32;

  logic          clk;
  logic          rst;
  logic          en_in;
  logic          flush_in;
  logic          cfg_load_in;
  logic [4:0]    cfg_delay_in;
  logic          src_valid_in;
  logic [BW-1:0] src_data_in;
  logic          dst_valid_out;
  logic [BW-1:0] dst_data_out;
  logic          busy_out;
  logic          cfg_err_out;
  logic [4:0]    cur_delay_out;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model: every enabled edge numbered T; samples older than clear_t are invalid.
  int            m_t;
  int            m_clear_t;
  int            m_delay;
  bit            m_fill;
  int            m_n;
  bit            m_err;
  bit            m_v [int];
  logic [BW-1:0] m_d [int];

  delay_line_var dut (
    .clk           (clk),
    .rst           (rst),
    .en_in         (en_in),
    .flush_in      (flush_in),
    .cfg_load_in   (cfg_load_in),
    .cfg_delay_in  (cfg_delay_in),
    .src_valid_in  (src_valid_in),
    .src_data_in   (src_data_in),
    .dst_valid_out (dst_valid_out),
    .dst_data_out  (dst_data_out),
    .busy_out      (busy_out),
    .cfg_err_out   (cfg_err_out),
    .cur_delay_out (cur_delay_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pk(input int k);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(k);
    b = 16'(-k);
    return {b, a};
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_t = 0;
      m_clear_t = 0;
      m_delay = 16;
      m_fill = 1'b0;
      m_n = 0;
      m_err = 1'b0;
      m_v.delete();
      m_d.delete();
    end else begin
      m_err = cfg_load_in && (int'(cfg_delay_in) > 16);
      if (en_in) begin
        m_t++;
        m_v[m_t] = src_valid_in;
        m_d[m_t] = src_data_in;
      end
      if (cfg_load_in) m_clear_t = en_in ? m_t - 1 : m_t;
      else if (flush_in) m_clear_t = m_t;
      if (cfg_load_in || flush_in) begin
        m_fill = 1'b1;
        m_n = 0;
      end else if (m_fill) begin
        if (m_delay == 0) m_fill = 1'b0;
        else if (en_in) begin
          m_n++;
          if (m_n >= m_delay - 1) m_fill = 1'b0;
        end
      end
      if (cfg_load_in) m_delay = (int'(cfg_delay_in) > 16) ? 16 : int'(cfg_delay_in);
    end
  endtask

  // One clock: drive, let the edge happen, update model, return after the negedge compare.
  task automatic cyc(input bit e, input bit v, input logic [BW-1:0] d,
                     input bit ld = 1'b0, input logic [4:0] dl = 5'd0,
                     input bit fl = 1'b0, input bit r = 1'b0);
    en_in = e;
    src_valid_in = v;
    src_data_in = d;
    cfg_load_in = ld;
    cfg_delay_in = dl;
    flush_in = fl;
    rst = r;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      bit            exp_v;
      logic [BW-1:0] exp_d;
      int            t;
      exp_v = 1'b0;
      exp_d = '0;
      if (m_delay == 0) begin
        exp_v = src_valid_in;
        exp_d = src_data_in;
      end else begin
        t = m_t - (m_delay - 1);
        if (t > m_clear_t && m_v.exists(t)) begin
          exp_v = m_v[t];
          exp_d = m_d[t];
        end
      end
      chk("dst_valid", BW'(dst_valid_out), BW'(exp_v));
      if (exp_v) chk("dst_data", dst_data_out, exp_d);
      chk("busy", BW'(busy_out), BW'(m_fill));
      chk("cur_delay", BW'(cur_delay_out), BW'(m_delay));
      chk("cfg_err", BW'(cfg_err_out), BW'(m_err));
    end
  end

  initial begin
    rst = 1'b1;
    en_in = 1'b0;
    flush_in = 1'b0;
    cfg_load_in = 1'b0;
    cfg_delay_in = 5'd0;
    src_valid_in = 1'b0;
    src_data_in = '0;
    chk_on = 1'b1;

    // Reset state
    cyc(0, 0, '0, 0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 0, 1);
    chk("rst_valid", BW'(dst_valid_out), 32'd0);
    chk("rst_data", dst_data_out, 32'd0);
    chk("rst_cur_delay", BW'(cur_delay_out), 32'd16);
    chk("rst_busy", BW'(busy_out), 32'd0);
    chk("rst_cfg_err", BW'(cfg_err_out), 32'd0);

    // Default D=16 stream
    for (int k = 1; k <= 40; k++) begin
      cyc(1, 1, pk(k));
      if (k == 15) chk("d16_not_yet", BW'(dst_valid_out), 32'd0);
      if (k == 16) begin
        chk("d16_first_valid", BW'(dst_valid_out), 32'd1);
        chk("d16_first_data", dst_data_out, 32'hFFFF0001);
      end
      if (k == 20) chk("d16_data5", dst_data_out, 32'hFFFB0005);
      if (k == 40) chk("d16_busy", BW'(busy_out), 32'd0);
    end

    // Load D=3 mid-stream
    cyc(1, 1, pk(41), 1, 5'd3);
    chk("d3_busy0", BW'(busy_out), 32'd1);
    chk("d3_valid0", BW'(dst_valid_out), 32'd0);
    chk("d3_cur", BW'(cur_delay_out), 32'd3);
    cyc(1, 1, pk(42));
    chk("d3_busy1", BW'(busy_out), 32'd1);
    chk("d3_valid1", BW'(dst_valid_out), 32'd0);
    cyc(1, 1, pk(43));
    chk("d3_busy2", BW'(busy_out), 32'd0);
    chk("d3_valid2", BW'(dst_valid_out), 32'd1);
    chk("d3_data_neg", dst_data_out, 32'hFFD70029);
    for (int k = 44; k <= 50; k++) cyc(1, 1, pk(k));

    // D=5 with enable pattern 1,0,0
    cyc(1, 1, pk(51), 1, 5'd5);
    for (int i = 1; i <= 12; i++) begin
      cyc((i % 3) == 1, 1, pk(51 + i));
      if (i == 9) begin
        chk("d5_busy_stall", BW'(busy_out), 32'd1);
        chk("d5_valid_stall", BW'(dst_valid_out), 32'd0);
      end
      if (i == 10) begin
        chk("d5_busy_done", BW'(busy_out), 32'd0);
        chk("d5_valid", BW'(dst_valid_out), 32'd1);
        chk("d5_data", dst_data_out, 32'hFFCD0033);
      end
      if (i == 11) chk("d5_hold", dst_data_out, 32'hFFCD0033);
    end

    // Out-of-range load saturates to 16
    cyc(1, 1, pk(70), 1, 5'd20);
    chk("err_pulse", BW'(cfg_err_out), 32'd1);
    chk("err_cur", BW'(cur_delay_out), 32'd16);
    cyc(1, 1, pk(71));
    chk("err_clear", BW'(cfg_err_out), 32'd0);
    for (int k = 72; k <= 95; k++) begin
      cyc(1, 1, pk(k));
      if (k == 84) chk("sat_not_yet", BW'(dst_valid_out), 32'd0);
      if (k == 85) chk("sat_data", dst_data_out, 32'hFFBA0046);
    end

    // D=0 bypass
    cyc(1, 1, pk(100), 1, 5'd0);
    chk("byp_load_valid", BW'(dst_valid_out), 32'd1);
    cyc(1, 1, 32'h7FFF7FFF);
    chk("byp_valid", BW'(dst_valid_out), 32'd1);
    chk("byp_data", dst_data_out, 32'h7FFF7FFF);
    cyc(1, 0, pk(3));
    chk("byp_invalid", BW'(dst_valid_out), 32'd0);
    cyc(0, 1, 32'h80018001);
    chk("byp_en0_data", dst_data_out, 32'h80018001);

    // Flush at D=4
    cyc(1, 1, pk(110), 1, 5'd4);
    for (int k = 111; k <= 119; k++) cyc(1, 1, pk(k));
    cyc(1, 1, pk(120), 0, 5'd0, 1);
    for (int k = 121; k <= 130; k++) begin
      cyc(1, 1, pk(k));
      if (k == 123) chk("flush_gap", BW'(dst_valid_out), 32'd0);
      if (k == 124) begin
        chk("flush_resume_valid", BW'(dst_valid_out), 32'd1);
        chk("flush_resume_data", dst_data_out, 32'hFF870079);
      end
    end

    // Load and flush together: load wins, same-edge sample kept
    cyc(1, 1, pk(131), 1, 5'd2, 1);
    chk("ldfl_cur", BW'(cur_delay_out), 32'd2);
    cyc(1, 1, pk(132));
    chk("ldfl_data", dst_data_out, 32'hFF7D0083);
    cyc(1, 1, pk(140), 1, 5'd3);
    for (int k = 141; k <= 145; k++) cyc(1, 1, pk(k));

    // Reset mid-stream
    cyc(1, 1, pk(146), 0, 5'd0, 0, 1);
    chk("mrst_valid", BW'(dst_valid_out), 32'd0);
    chk("mrst_cur", BW'(cur_delay_out), 32'd16);
    chk("mrst_busy", BW'(busy_out), 32'd0);
    chk("mrst_data", dst_data_out, 32'd0);
    for (int i = 0; i < 20; i++) cyc(1, 0, pk(150 + i));
    for (int i = 0; i < 4; i++) cyc(1, 1, pk(200 + i));

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
